// File: rtl/cpu_riscv_pipe.sv
// cpu_riscv_pipe: three-stage (fetch / execute / writeback) RV32I/RV64I integer subset core.
// Optional feature: define CPU_RISCV_PIPE_FWD_EN to forward the W result into E operands;
// without it a read-after-write hazard on the W instruction costs one stall cycle.
module cpu_riscv_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_valid,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  illegal
);

  localparam int unsigned PW  = ADDR_WIDTH + 2;
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_B   = 7'b1100011;

  logic [PW-1:0]   pc;
  logic            fe_valid;
  logic [31:0]     fe_instr;
  logic [PW-1:0]   fe_pc;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_r, r_ok, is_addi, is_lui, is_br;
  logic            uses_rs1, uses_rs2, writes, supported;
  logic            hazard1, hazard2, stall, taken, retire;
  logic [XLEN-1:0] rs1_rf, rs2_rf, a, b, imm_i, imm_u, alu;
  logic [PW-1:0]   imm_b, br_target;

  assign imem_addr = pc[PW-1:2];

  // Decode of the instruction held in F/E
  assign opcode = fe_instr[6:0];
  assign rd     = fe_instr[11:7];
  assign funct3 = fe_instr[14:12];
  assign rs1    = fe_instr[19:15];
  assign rs2    = fe_instr[24:20];
  assign funct7 = fe_instr[31:25];

  assign is_r    = (opcode == OP_R);
  assign r_ok    = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
  assign is_addi = (opcode == OP_I) && (funct3 == 3'd0);
  assign is_lui  = (opcode == OP_LUI);
  assign is_br   = (opcode == OP_B) && (funct3[2:1] == 2'b00);

  assign uses_rs1  = (is_r && r_ok) || is_addi || is_br;
  assign uses_rs2  = (is_r && r_ok) || is_br;
  assign writes    = (is_r && r_ok) || is_addi || is_lui;
  assign supported = writes || is_br;
  assign illegal   = fe_valid && !supported;

  // Sign-extended immediates; the branch offset only matters modulo the pc width
  assign imm_i = XLEN'($signed(fe_instr[31:20]));
  assign imm_u = XLEN'($signed({fe_instr[31:12], 12'b0}));
  assign imm_b = PW'($signed({fe_instr[31], fe_instr[7], fe_instr[30:25], fe_instr[11:8], 1'b0}));

  assign rs1_rf = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_rf = (rs2 == 5'd0) ? '0 : rf[rs2];

  // RAW hazard against the instruction currently in W (x0 never carries a dependency)
  assign hazard1 = fe_valid && wb_valid && (wb_rd != 5'd0) && uses_rs1 && (wb_rd == rs1);
  assign hazard2 = fe_valid && wb_valid && (wb_rd != 5'd0) && uses_rs2 && (wb_rd == rs2);

`ifdef CPU_RISCV_PIPE_FWD_EN
  assign stall = 1'b0;
  assign a     = hazard1 ? wb_data : rs1_rf;
  assign b     = hazard2 ? wb_data : rs2_rf;
`else
  assign stall = hazard1 || hazard2;
  assign a     = rs1_rf;
  assign b     = rs2_rf;
`endif

  assign taken     = fe_valid && !stall && is_br && ((a == b) ^ funct3[0]);
  assign br_target = (fe_pc + imm_b) & ~PW'(3);
  assign retire    = fe_valid && !stall && writes;

  // ALU result for the E instruction
  always_comb begin
    alu = '0;
    if (is_lui) begin
      alu = imm_u;
    end else if (is_addi) begin
      alu = a + imm_i;
    end else begin
      case (funct3)
        3'd0:    alu = funct7[5] ? (a - b) : (a + b);
        3'd1:    alu = a << b[SHW-1:0];
        3'd2:    alu = XLEN'($signed(a) < $signed(b));
        3'd3:    alu = XLEN'(a < b);
        3'd4:    alu = a ^ b;
        3'd5:    alu = funct7[5] ? XLEN'($signed(a) >>> b[SHW-1:0]) : (a >> b[SHW-1:0]);
        3'd6:    alu = a | b;
        default: alu = a & b;
      endcase
    end
  end

  // Fetch: pc update and F/E register (taken branch beats stall and fetch stall)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PW'(RESET_PC);
      fe_valid <= 1'b0;
      fe_instr <= '0;
      fe_pc    <= '0;
    end else if (taken) begin
      pc       <= br_target;
      fe_valid <= 1'b0;
    end else if (!stall) begin
      if (imem_valid) begin
        fe_valid <= 1'b1;
        fe_instr <= imem_rdata;
        fe_pc    <= pc;
        pc       <= pc + PW'(4);
      end else begin
        fe_valid <= 1'b0;
      end
    end
  end

  // E -> W register; stalls and non-writing instructions become bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= retire;
      wb_rd    <= retire ? rd : 5'd0;
      wb_data  <= (retire && (rd != 5'd0)) ? alu : '0;
    end
  end

  // Register file write at the end of the W cycle; entry 0 stays zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_riscv_pipe.sv
// tb_cpu_riscv_pipe: directed program tests for cpu_riscv_pipe (32-bit and 64-bit instances).
module tb_cpu_riscv_pipe;

  localparam logic [31:0] HALT = 32'h0000_0063;  // BEQ x0,x0,0

`ifdef CPU_RISCV_PIPE_FWD_EN
  localparam int ADD_REL = 4;
`else
  localparam int ADD_REL = 5;
`endif

  typedef struct {
    int          rel;
    logic [4:0]  rd;
    logic [31:0] d;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b1;
  logic [31:0] mem [128];

  logic [6:0]  imem_addr32, imem_addr64;
  logic [31:0] imem_rdata32, imem_rdata64;
  logic        wb_valid32, wb_valid64, illegal32, illegal64;
  logic [4:0]  wb_rd32, wb_rd64;
  logic [31:0] wb_data32;
  logic [63:0] wb_data64;

  int   cyc = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;
  ret_t rq[$];
  int   iq[$];

  assign imem_rdata32 = mem[imem_addr32];
  assign imem_rdata64 = mem[imem_addr64];

  cpu_riscv_pipe #(.XLEN(32), .ADDR_WIDTH(7), .RESET_PC(0)) u_dut32 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr32), .imem_rdata(imem_rdata32),
    .imem_valid(imem_valid), .wb_valid(wb_valid32), .wb_rd(wb_rd32),
    .wb_data(wb_data32), .illegal(illegal32)
  );

  cpu_riscv_pipe #(.XLEN(64), .ADDR_WIDTH(7), .RESET_PC(0)) u_dut64 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr64), .imem_rdata(imem_rdata64),
    .imem_valid(imem_valid), .wb_valid(wb_valid64), .wb_rd(wb_rd64),
    .wb_data(wb_data64), .illegal(illegal64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Retirement and illegal-pulse log of the 32-bit core, stamped with cycles since reset
  always @(negedge clk) begin
    ret_t r;
    if (wb_valid32 === 1'b1) begin
      r.rel = cyc - base;
      r.rd  = wb_rd32;
      r.d   = wb_data32;
      rq.push_back(r);
    end
    if (illegal32 === 1'b1) iq.push_back(cyc - base);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic ret_t get(input int idx);
    ret_t r;
    r.rel = -1;
    r.rd  = 'x;
    r.d   = 'x;
    if (idx < rq.size()) r = rq[idx];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input int idx, input int rel,
                         input logic [4:0] rd, input logic [31:0] d);
    ret_t r;
    r = get(idx);
    chk({tag, ".rd"}, 64'(r.rd), 64'(rd));
    chk({tag, ".data"}, 64'(r.d), 64'(d));
    if (rel >= 0) chk({tag, ".cycle"}, 64'(r.rel), 64'(rel));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = HALT;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    rq.delete();
    iq.delete();
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - base) < n) @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state + dependent ADD chain ----------------
    clear_mem();
    mem[0] = enc_addi(5'd1, 5'd0, 12'd5);
    mem[1] = enc_addi(5'd2, 5'd0, 12'd7);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    do_reset();
    chk("reset.imem_addr", 64'(imem_addr32), 64'd0);
    chk("reset.wb_valid", 64'(wb_valid32), 64'd0);
    chk("reset.wb_rd", 64'(wb_rd32), 64'd0);
    chk("reset.wb_data", 64'(wb_data32), 64'd0);
    chk("reset.illegal", 64'(illegal32), 64'd0);
    wait_rel(12);
    #1;
    chk_ret("add.i0", 0, 2, 5'd1, 32'd5);
    chk_ret("add.i1", 1, 3, 5'd2, 32'd7);
    chk_ret("add.i2", 2, ADD_REL, 5'd3, 32'd12);
    chk("add.count", 64'(rq.size()), 64'd3);

    // ---------------- taken BEQ with one-cycle flush ----------------
    clear_mem();
    mem[0] = enc_addi(5'd1, 5'd0, 12'd5);
    mem[1] = enc_addi(5'd2, 5'd0, 12'd5);
    mem[2] = enc_addi(5'd6, 5'd0, 12'd1);
    mem[3] = enc_addi(5'd7, 5'd0, 12'd2);
    mem[4] = enc_br(3'd0, 5'd1, 5'd2, 13'd8);
    mem[5] = enc_addi(5'd8, 5'd0, 12'd99);
    mem[6] = enc_addi(5'd9, 5'd0, 12'd3);
    do_reset();
    wait_rel(6);
    chk("beq.pc_target", 64'(imem_addr32), 64'd6);
    wait_rel(14);
    #1;
    chk_ret("beq.i0", 0, 2, 5'd1, 32'd5);
    chk_ret("beq.i1", 1, 3, 5'd2, 32'd5);
    chk_ret("beq.i2", 2, 4, 5'd6, 32'd1);
    chk_ret("beq.i3", 3, 5, 5'd7, 32'd2);
    chk_ret("beq.target", 4, 8, 5'd9, 32'd3);
    chk("beq.count", 64'(rq.size()), 64'd5);

    // ---------------- writes to x0 ----------------
    clear_mem();
    mem[0] = enc_addi(5'd0, 5'd0, 12'd9);
    mem[1] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4);
    do_reset();
    wait_rel(8);
    #1;
    chk_ret("x0.addi", 0, 2, 5'd0, 32'd0);
    chk_ret("x0.add", 1, 3, 5'd4, 32'd0);
    chk("x0.count", 64'(rq.size()), 64'd2);

    // ---------------- fetch stall for three cycles ----------------
    clear_mem();
    mem[0] = enc_addi(5'd1, 5'd0, 12'd1);
    mem[1] = enc_addi(5'd2, 5'd0, 12'd2);
    mem[2] = enc_addi(5'd3, 5'd0, 12'd3);
    mem[3] = enc_addi(5'd4, 5'd0, 12'd4);
    do_reset();
    wait_rel(2);
    imem_valid = 1'b0;
    wait_rel(3);
    chk("stall.pc_c3", 64'(imem_addr32), 64'd2);
    wait_rel(4);
    chk("stall.pc_c4", 64'(imem_addr32), 64'd2);
    wait_rel(5);
    chk("stall.pc_c5", 64'(imem_addr32), 64'd2);
    imem_valid = 1'b1;
    wait_rel(12);
    #1;
    chk_ret("stall.i0", 0, 2, 5'd1, 32'd1);
    chk_ret("stall.i1", 1, 3, 5'd2, 32'd2);
    chk_ret("stall.i2", 2, 7, 5'd3, 32'd3);
    chk_ret("stall.i3", 3, 8, 5'd4, 32'd4);
    chk("stall.count", 64'(rq.size()), 64'd4);

    // ---------------- illegal opcode, then LUI sign extension ----------------
    clear_mem();
    mem[0] = 32'h0000_007F;
    mem[1] = enc_lui(5'd5, 20'h80000);
    do_reset();
    chk("ill.before", 64'(illegal32), 64'd0);
    wait_rel(1);
    chk("ill.pulse", 64'(illegal32), 64'd1);
    chk("ill.pulse64", 64'(illegal64), 64'd1);
    wait_rel(2);
    chk("ill.after", 64'(illegal32), 64'd0);
    chk("ill.wb_valid", 64'(wb_valid32), 64'd0);
    chk("ill.wb_valid64", 64'(wb_valid64), 64'd0);
    wait_rel(3);
    chk("lui64.valid", 64'(wb_valid64), 64'd1);
    chk("lui64.rd", 64'(wb_rd64), 64'd5);
    chk("lui64.data", wb_data64, 64'hFFFF_FFFF_8000_0000);
    wait_rel(10);
    #1;
    chk_ret("lui32", 0, 3, 5'd5, 32'h8000_0000);
    chk("lui32.count", 64'(rq.size()), 64'd1);
    chk("ill.count", 64'(iq.size()), 64'd1);

    // ---------------- reset with instructions in flight ----------------
    clear_mem();
    mem[0] = enc_addi(5'd1, 5'd0, 12'd11);
    mem[1] = enc_addi(5'd2, 5'd0, 12'd22);
    mem[2] = enc_addi(5'd3, 5'd0, 12'd33);
    do_reset();
    wait_rel(2);
    chk("midrst.inflight", 64'(wb_valid32), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = cyc;
    rq.delete();
    iq.delete();
    chk("midrst.wb_valid", 64'(wb_valid32), 64'd0);
    chk("midrst.wb_rd", 64'(wb_rd32), 64'd0);
    chk("midrst.pc", 64'(imem_addr32), 64'd0);
    clear_mem();
    mem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10);
    mem[1] = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd11);
    mem[2] = enc_r(7'h00, 5'd3, 5'd1, 3'd6, 5'd12);
    wait_rel(10);
    #1;
    chk_ret("midrst.rd_x1x2", 0, 2, 5'd10, 32'd0);
    chk_ret("midrst.rd_x3", 1, 3, 5'd11, 32'd0);
    chk_ret("midrst.rd_x1x3", 2, 4, 5'd12, 32'd0);
    chk("midrst.count", 64'(rq.size()), 64'd3);

    // ---------------- ALU operations, BNE taken, BEQ not taken ----------------
    clear_mem();
    mem[0]  = enc_addi(5'd1, 5'd0, 12'hFF8);
    mem[1]  = enc_addi(5'd2, 5'd0, 12'd35);
    mem[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
    mem[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd4);
    mem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd5);
    mem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd6);
    mem[6]  = enc_r(7'h00, 5'd2, 5'd2, 3'd1, 5'd7);
    mem[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd8);
    mem[8]  = enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd10);
    mem[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd11);
    mem[10] = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd12);
    mem[11] = enc_br(3'd1, 5'd1, 5'd2, 13'd8);
    mem[12] = enc_addi(5'd13, 5'd0, 12'd1);
    mem[13] = enc_addi(5'd14, 5'd0, 12'd2);
    mem[14] = enc_br(3'd0, 5'd1, 5'd2, 13'd8);
    mem[15] = enc_addi(5'd15, 5'd0, 12'd5);
    do_reset();
    wait_rel(2);
    chk("alu.addi64", wb_data64, 64'hFFFF_FFFF_FFFF_FFF8);
    wait_rel(30);
    #1;
    chk_ret("alu.addi_neg", 0, 2, 5'd1, 32'hFFFF_FFF8);
    chk_ret("alu.addi", 1, 3, 5'd2, 32'h0000_0023);
    chk_ret("alu.sub", 2, -1, 5'd3, 32'hFFFF_FFD5);
    chk_ret("alu.and", 3, -1, 5'd4, 32'h0000_0020);
    chk_ret("alu.or", 4, -1, 5'd5, 32'hFFFF_FFFB);
    chk_ret("alu.xor", 5, -1, 5'd6, 32'hFFFF_FFDB);
    chk_ret("alu.sll", 6, -1, 5'd7, 32'h0000_0118);
    chk_ret("alu.srl", 7, -1, 5'd8, 32'h1FFF_FFFF);
    chk_ret("alu.sra", 8, -1, 5'd10, 32'hFFFF_FFFF);
    chk_ret("alu.slt", 9, -1, 5'd11, 32'd1);
    chk_ret("alu.sltu", 10, -1, 5'd12, 32'd0);
    chk_ret("alu.bne_target", 11, -1, 5'd14, 32'd2);
    chk_ret("alu.beq_fallthru", 12, -1, 5'd15, 32'd5);
    chk("alu.count", 64'(rq.size()), 64'd13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_riscv_pipe.md
CPU_RISCV_PIPE -- requirements
Module: cpu_riscv_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and register width (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: instruction-memory word-address width.
REQ-003 SHALL have parameter RESET_PC, default 0: byte address loaded into pc at reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_addr  output  ADDR_WIDTH  word address of the fetch, equal to pc[ADDR_WIDTH+1:2].
REQ-007 SHALL have port imem_rdata  input  32  instruction at imem_addr, valid in the same cycle.
REQ-008 SHALL have port imem_valid  input  1  imem_rdata usable this cycle; low means fetch stall.
REQ-009 SHALL have port wb_valid  output  1  one instruction retires this cycle.
REQ-010 SHALL have port wb_rd  output  5  destination register of the retiring instruction.
REQ-011 SHALL have port wb_data  output  XLEN  value written by the retiring instruction.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse when E holds an unsupported opcode.

Function
REQ-013 SHALL implement three stages: F (fetch into the F/E register), E (decode, regfile read, ALU, branch resolve) and W (regfile write, retire port).
REQ-014 SHALL support: R-type ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; ADDI; LUI; BEQ; BNE. Shift amounts use the low log2(XLEN) bits.
REQ-015 SHALL sign-extend all immediates to XLEN; LUI result = {imm[31:12], 12'b0} sign-extended.
REQ-016 SHALL compute arithmetic modulo 2^XLEN with no overflow flag.
REQ-017 SHALL form pc as an ADDR_WIDTH+2 bit byte address that wraps modulo 2^(ADDR_WIDTH+2).
REQ-018 SHALL, on an edge with imem_valid=1 and no stall or flush, latch imem_rdata and pc into F/E, mark F/E valid, and set pc = pc+4.
REQ-019 SHALL, on an edge with imem_valid=0, hold pc and load a bubble (valid=0) into F/E.
REQ-020 SHALL retire instruction n in W exactly 2 cycles after it is latched into F/E, absent stalls; the regfile write occurs on the edge that ends the W cycle.
REQ-021 SHALL, for a taken BEQ/BNE in E, set pc = branch_pc + B-immediate with bits [1:0] forced to 0, and flush the concurrently fetched instruction to a bubble (1-cycle penalty); a not-taken branch costs no cycles.
REQ-022 SHALL make branches, bubbles and unsupported opcodes enter W with wb_valid=0.
REQ-023 SHALL never write x0; reads of x0 return 0; an instruction with rd=x0 retires with wb_valid=1, wb_rd=0, wb_data=0.
REQ-024 SHALL pulse illegal for exactly one cycle per unsupported instruction while it is in E, treating it as a NOP.
REQ-025 SHALL give a taken branch priority over imem_valid=0: pc takes the target and F/E holds a bubble.

Reset
REQ-026 SHALL, on a clock edge with reset=1, set pc=RESET_PC, set F/E and W valid to 0, and clear all 31 registers to 0.
REQ-027 SHALL drive after reset: imem_addr=RESET_PC[ADDR_WIDTH+1:2], wb_valid=0, wb_rd=0, wb_data=0, illegal=0.
REQ-028 SHALL let reset asserted mid-operation discard in-flight instructions with no regfile write on that edge.

Configuration
REQ-029 SHALL, with macro CPU_RISCV_PIPE_FWD_EN defined, forward the W result to E operands when W is valid, W rd = E rs1/rs2 and rd!=0, with no stall.
REQ-030 SHALL, without CPU_RISCV_PIPE_FWD_EN, detect the same hazard and stall for one cycle: hold pc and F/E, and insert a bubble into W. Retired results SHALL be identical in both builds; only timing differs.

Verification
REQ-031 SHALL verify ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 -> x3=12. With FWD_EN, retirement is on 3 consecutive cycles; without it, 1 bubble cycle precedes each dependent retire.
REQ-032 SHALL verify x1=5, x2=5; BEQ x1,x2,+8 at pc 0x10 -> next retired pc 0x18, the instruction at 0x14 never retires, and exactly 1 bubble occurs.
REQ-033 SHALL verify ADDI x0,x0,9 then ADD x4,x0,x0 -> wb_rd=0, wb_data=0, then x4=0.
REQ-034 SHALL verify imem_valid low for 3 cycles mid-stream -> pc is held, 3 bubbles occur, and no instruction is lost or duplicated.
REQ-035 SHALL verify opcode 0x7F -> illegal high for 1 cycle and wb_valid=0; then XLEN=64: LUI x5,0x80000 -> x5=0xFFFFFFFF80000000.
REQ-036 SHALL verify reset asserted with 2 instructions in flight -> no retire, pc=RESET_PC, all registers read 0.
